// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/ready handshake between fetch stage and imem
interface fetch_pc_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: IF stage owning the PC, issuing imem fetches and redirecting on EX branches
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [31:0]     branch_target,
   fetch_pc_unit_if.master imem,
   output logic            if_valid,
   output logic [31:0]     if_pc,
   output logic [31:0]     if_instr,
   output logic            flush
);
   typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;
   state_t      state;
   logic        req;
   logic [31:0] pc, instr_q, buf_pc, buf_instr, pending, pc_inc, tgt;
   assign pc_inc         = pc + 32'd4;
   assign tgt            = {branch_target[31:2], 2'b00};
   assign imem.imem_req  = req;
   assign imem.imem_addr = pc;
   assign flush          = branch_taken;
   assign if_instr       = if_valid ? instr_q : NOP_INSTR;
   // fetch FSM: HOLD parks a word returned under stall, DRAIN retires a request orphaned by a branch
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state     <= BOOT;
         req       <= 1'b0;
         pc        <= RESET_PC;
         if_valid  <= 1'b0;
         if_pc     <= RESET_PC;
         instr_q   <= NOP_INSTR;
         buf_pc    <= RESET_PC;
         buf_instr <= NOP_INSTR;
         pending   <= RESET_PC;
      end else
         case (state)
            BOOT: begin
               state <= FETCH;
               req   <= 1'b1;
            end
            FETCH:
               if (branch_taken) begin
                  if_valid <= 1'b0;
                  if (imem.imem_ready) pc <= tgt;
                  else begin
                     pending <= tgt;
                     state   <= DRAIN;
                  end
               end else if (imem.imem_ready) begin
                  pc <= pc_inc;
                  if (stall) begin
                     buf_pc    <= pc;
                     buf_instr <= imem.imem_rdata;
                     state     <= HOLD;
                     req       <= 1'b0;
                  end else begin
                     if_pc    <= pc;
                     instr_q  <= imem.imem_rdata;
                     if_valid <= 1'b1;
                  end
               end else if (!stall) if_valid <= 1'b0;
            HOLD:
               if (branch_taken) begin
                  pc       <= tgt;
                  if_valid <= 1'b0;
                  state    <= FETCH;
                  req      <= 1'b1;
               end else if (!stall) begin
                  if_pc    <= buf_pc;
                  instr_q  <= buf_instr;
                  if_valid <= 1'b1;
                  state    <= FETCH;
                  req      <= 1'b1;
               end
            DRAIN:
               if (imem.imem_ready) begin
                  pc    <= branch_taken ? tgt : pending;
                  state <= FETCH;
               end else if (branch_taken) pending <= tgt;
            default: state <= BOOT;
         endcase
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed bench with a scoreboard of instructions the ID stage should consume
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        reset_n, stall, br, rdy;
   logic [31:0] tgt;
   logic        if_valid, flush;
   logic [31:0] if_pc, if_instr;
   logic [31:0] exp_q[$];
   int          n_chk = 0, n_fail = 0;
   fetch_pc_unit_if mif ();
   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction
   assign mif.imem_ready = rdy;
   assign mif.imem_rdata = mem(mif.imem_addr);
   fetch_pc_unit dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .branch_taken(br), .branch_target(tgt),
      .imem(mif), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // ID stage model: a live, unstalled, unflushed IF/ID word is consumed at the coming edge
   always @(negedge clk)
      if (reset_n === 1'b1 && if_valid === 1'b1 && !stall && !br) begin
         n_chk++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed pc=%h expected=none", if_pc);
         end
         if (exp_q.size() > 0) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("sb_pc", if_pc, e);
            chk("sb_instr", if_instr, mem(e));
         end
      end
   initial begin
      reset_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; rdy = 1'b1;
      tick; tick;
      chk("rst_req", mif.imem_req, 0);
      chk("rst_addr", mif.imem_addr, 32'h0);
      chk("rst_valid", if_valid, 0);
      chk("rst_pc", if_pc, 32'h0);
      chk("rst_instr", if_instr, 32'h13);
      chk("rst_flush", flush, 0);
      // T1: zero-wait streaming
      reset_n = 1'b1;
      tick;
      chk("t1_req", mif.imem_req, 1);
      chk("t1_addr0", mif.imem_addr, 32'h0);
      chk("t1_valid0", if_valid, 0);
      exp_q.push_back(32'h0); exp_q.push_back(32'h4);
      tick;
      chk("t1_addr4", mif.imem_addr, 32'h4);
      chk("t1_valid1", if_valid, 1);
      chk("t1_pc0", if_pc, 32'h0);
      tick;
      chk("t1_addr8", mif.imem_addr, 32'h8);
      chk("t1_pc4", if_pc, 32'h4);
      tick;
      chk("t1_pc8", if_pc, 32'h8);
      // T2: branch with ready memory
      br = 1'b1; tgt = 32'h100;
      #1 chk("t2_flush", flush, 1);
      tick;
      br = 1'b0;
      #1 chk("t2_flush_off", flush, 0);
      chk("t2_bubble", if_valid, 0);
      chk("t2_addr", mif.imem_addr, 32'h100);
      exp_q.push_back(32'h100);
      tick;
      chk("t2_pc", if_pc, 32'h100);
      chk("t2_valid", if_valid, 1);
      // T3: branch while memory stalls, last target wins
      rdy = 1'b0;
      tick;
      chk("t3_bubble", if_valid, 0);
      chk("t3_addr_a", mif.imem_addr, 32'h104);
      br = 1'b1; tgt = 32'h280;
      tick;
      chk("t3_addr_b", mif.imem_addr, 32'h104);
      chk("t3_req", mif.imem_req, 1);
      tgt = 32'h301;
      tick;
      br = 1'b0;
      chk("t3_addr_c", mif.imem_addr, 32'h104);
      chk("t3_valid_c", if_valid, 0);
      tick;
      chk("t3_addr_d", mif.imem_addr, 32'h104);
      rdy = 1'b1;
      exp_q.push_back(32'h300);
      tick;
      chk("t3_target", mif.imem_addr, 32'h300);
      chk("t3_drop", if_valid, 0);
      tick;
      chk("t3_pc", if_pc, 32'h300);
      tick;
      // T4: stall while the fetch at 0x20 completes
      br = 1'b1; tgt = 32'h18;
      tick;
      br = 1'b0;
      exp_q.push_back(32'h18); exp_q.push_back(32'h1C);
      tick;
      chk("t4_pc18", if_pc, 32'h18);
      tick;
      chk("t4_addr20", mif.imem_addr, 32'h20);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("t4_hold_req", mif.imem_req, 0);
         chk("t4_hold_pc", if_pc, 32'h1C);
         chk("t4_hold_valid", if_valid, 1);
      end
      stall = 1'b0;
      exp_q.push_back(32'h20);
      tick;
      chk("t4_pc20", if_pc, 32'h20);
      chk("t4_req", mif.imem_req, 1);
      chk("t4_addr24", mif.imem_addr, 32'h24);
      tick;
      chk("t4_pc24", if_pc, 32'h24);
      // T5: branch inside HOLD, misaligned target
      stall = 1'b1;
      tick;
      chk("t5_hold", mif.imem_req, 0);
      br = 1'b1; tgt = 32'h203;
      #1 chk("t5_flush", flush, 1);
      tick;
      br = 1'b0; stall = 1'b0;
      chk("t5_addr", mif.imem_addr, 32'h200);
      chk("t5_req", mif.imem_req, 1);
      chk("t5_bubble", if_valid, 0);
      exp_q.push_back(32'h200);
      tick;
      chk("t5_pc", if_pc, 32'h200);
      // T6: async reset mid-request, then PC wrap
      rdy = 1'b0;
      tick;
      chk("t6_pending_req", mif.imem_req, 1);
      chk("t6_pending_addr", mif.imem_addr, 32'h204);
      reset_n = 1'b0;
      #1;
      chk("t6_req_drop", mif.imem_req, 0);
      chk("t6_addr_rst", mif.imem_addr, 32'h0);
      chk("t6_valid_rst", if_valid, 0);
      chk("t6_instr_rst", if_instr, 32'h13);
      tick;
      reset_n = 1'b1; rdy = 1'b1;
      tick;
      chk("t6_restart", mif.imem_addr, 32'h0);
      chk("t6_restart_req", mif.imem_req, 1);
      br = 1'b1; tgt = 32'hFFFF_FFF8;
      tick;
      br = 1'b0;
      chk("t6_addr_f8", mif.imem_addr, 32'hFFFF_FFF8);
      exp_q.push_back(32'hFFFF_FFF8); exp_q.push_back(32'hFFFF_FFFC);
      tick;
      chk("t6_addr_fc", mif.imem_addr, 32'hFFFF_FFFC);
      tick;
      chk("t6_wrap_addr", mif.imem_addr, 32'h0);
      chk("t6_pc_fc", if_pc, 32'hFFFF_FFFC);
      tick;
      chk("t6_wrap_pc", if_pc, 32'h0);
      stall = 1'b1;
      tick; tick;
      chk("sb_leftover", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
